// File: rtl/gcd_unit.sv
// Iterative Euclid GCD engine: one remainder step per clock. The remainder comes
// from a combinational restoring divider (gcd_mod) instantiated below.

module gcd_mod #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_dividend,
  input  logic [W-1:0] i_divisor,
  output logic [W-1:0] o_remainder
);

  logic [W:0]   w_trial;
  logic [W:0]   w_diff;
  logic [W-1:0] w_rem;

  // Restoring long division, MSB first; only the remainder is kept
  always_comb begin
    w_rem   = {W{1'b0}};
    w_trial = {(W+1){1'b0}};
    w_diff  = {(W+1){1'b0}};
    for (int i = W - 1; i >= 0; i--) begin
      w_trial = {w_rem, i_dividend[i]};
      w_diff  = w_trial - {1'b0, i_divisor};
      if (w_trial >= {1'b0, i_divisor}) begin
        w_rem = w_diff[W-1:0];
      end else begin
        w_rem = w_trial[W-1:0];
      end
    end
    o_remainder = w_rem;
  end

endmodule

module gcd_unit #(
  parameter int DATAWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] a_in,
  input  logic [DATAWIDTH-1:0] b_in,
  output logic                 busy,
  output logic                 done,
  output logic [DATAWIDTH-1:0] gcd_out,
  output logic                 err,
  output logic [3:0]           iter_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [DATAWIDTH-1:0]   r_ra;
  logic [DATAWIDTH-1:0]   r_rb;
  logic [DATAWIDTH-1:0]   r_gcd;
  logic                   r_err;
  logic [3:0]             r_iter;
  logic                   r_busy;
  logic                   r_done;

  logic [DATAWIDTH-1:0]   w_ra_nxt;
  logic [DATAWIDTH-1:0]   w_rb_nxt;
  logic [DATAWIDTH-1:0]   w_gcd_nxt;
  logic                   w_err_nxt;
  logic [3:0]             w_iter_nxt;
  logic                   w_busy_nxt;
  logic                   w_done_nxt;

  logic                   w_both_zero;
  logic                   w_rb_zero;
  logic [DATAWIDTH-1:0]   w_divisor;
  logic [DATAWIDTH-1:0]   w_rem;

  assign w_both_zero = (a_in == {DATAWIDTH{1'b0}}) && (b_in == {DATAWIDTH{1'b0}});
  assign w_rb_zero   = (r_rb == {DATAWIDTH{1'b0}});
  // Divisor is forced to 1 when rb is zero so the divider never sees zero
  assign w_divisor   = w_rb_zero ? {{(DATAWIDTH-1){1'b0}}, 1'b1} : r_rb;

  gcd_mod #(
    .W (DATAWIDTH)
  ) u_mod (
    .i_dividend  (r_ra),
    .i_divisor   (w_divisor),
    .o_remainder (w_rem)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = w_both_zero ? ST_DONE : ST_CALC;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (w_rb_zero) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_CALC;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath and output next values; everything holds unless a state acts on it
  always_comb begin
    w_ra_nxt   = r_ra;
    w_rb_nxt   = r_rb;
    w_gcd_nxt  = r_gcd;
    w_err_nxt  = r_err;
    w_iter_nxt = r_iter;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_ra_nxt   = a_in;
          w_rb_nxt   = b_in;
          w_iter_nxt = 4'd0;
          w_err_nxt  = w_both_zero;
          if (w_both_zero) begin
            w_gcd_nxt = {DATAWIDTH{1'b0}};
          end else begin
            w_gcd_nxt = r_gcd;
          end
        end else begin
          w_ra_nxt = r_ra;
        end
      end
      ST_CALC: begin
        if (w_rb_zero) begin
          w_gcd_nxt = r_ra;
        end else begin
          w_ra_nxt   = r_rb;
          w_rb_nxt   = w_rem;
          w_iter_nxt = (r_iter == 4'd15) ? 4'd15 : (r_iter + 4'd1);
        end
      end
      ST_DONE: w_ra_nxt = r_ra;
      default: w_ra_nxt = r_ra;
    endcase
    w_busy_nxt = (w_state_nxt == ST_CALC);
    w_done_nxt = (w_state_nxt == ST_DONE);
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ra   <= {DATAWIDTH{1'b0}};
      r_rb   <= {DATAWIDTH{1'b0}};
      r_gcd  <= {DATAWIDTH{1'b0}};
      r_err  <= 1'b0;
      r_iter <= 4'd0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_ra   <= w_ra_nxt;
      r_rb   <= w_rb_nxt;
      r_gcd  <= w_gcd_nxt;
      r_err  <= w_err_nxt;
      r_iter <= w_iter_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign gcd_out  = r_gcd;
  assign err      = r_err;
  assign iter_cnt = r_iter;

endmodule

// File: tb/tb_gcd_unit.sv
// Self-checking bench for gcd_unit: directed vector table, hand-written corner
// sequences, and random operands checked against a plain-arithmetic Euclid model.
`timescale 1ns/1ps

module tb_gcd_unit;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       busy;
  logic       done;
  logic [7:0] gcd_out;
  logic       err;
  logic [3:0] iter_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  gcd_unit #(.DATAWIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a_in     (a_in),
    .b_in     (b_in),
    .busy     (busy),
    .done     (done),
    .gcd_out  (gcd_out),
    .err      (err),
    .iter_cnt (iter_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    int         g;
    int         n;
    bit         e;
    int         edges;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", nm, act, exp);
    end
  endtask

  // Reference: textbook Euclid with the % operator
  function automatic void ref_gcd(input int a, input int b, output int g, output int n,
                                  output bit e, output int edges);
    int t;
    int steps;
    e = (a == 0) && (b == 0);
    steps = 0;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
      steps++;
    end
    g = a;
    n = (steps > 15) ? 15 : steps;
    edges = e ? 0 : steps + 1;
  endfunction

  task automatic wait_done(output int k);
    k = 0;
    while (!done && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  // Start edge is the next rising edge; inputs must already be driven
  task automatic go(input string nm, input int eg, input int en, input bit ee, input int edges);
    int k;
    @(posedge clk); #1;
    start = 1'b0;
    check({nm, " busy"}, busy, !ee);
    wait_done(k);
    check({nm, " edges"}, k, edges);
    check({nm, " gcd"}, gcd_out, eg);
    check({nm, " iter"}, iter_cnt, en);
    check({nm, " err"}, err, ee);
    @(posedge clk); #1;
    check({nm, " done_pulse"}, done, 0);
  endtask

  task automatic run_op(input string nm, input logic [7:0] a, input logic [7:0] b,
                        input int eg, input int en, input bit ee, input int edges);
    @(negedge clk);
    a_in = a; b_in = b; start = 1'b1;
    go(nm, eg, en, ee, edges);
  endtask

  initial begin
    vec_t vecs[10];
    int   g, n, edges, k, bad;
    bit   e;
    logic [8:0] mask;
    logic [7:0] ra, rb;

    vecs[0] = '{8'd7,   8'd2,   1,   2,  1'b0, 3};
    vecs[1] = '{8'd5,   8'd13,  1,   5,  1'b0, 6};
    vecs[2] = '{8'd25,  8'd5,   5,   1,  1'b0, 2};
    vecs[3] = '{8'd0,   8'd12,  12,  1,  1'b0, 2};
    vecs[4] = '{8'd39,  8'd0,   39,  0,  1'b0, 1};
    vecs[5] = '{8'd0,   8'd0,   0,   0,  1'b1, 0};
    vecs[6] = '{8'd144, 8'd233, 1,   12, 1'b0, 13};
    vecs[7] = '{8'd255, 8'd255, 255, 1,  1'b0, 2};
    vecs[8] = '{8'd48,  8'd18,  6,   3,  1'b0, 4};
    vecs[9] = '{8'd1,   8'd1,   1,   1,  1'b0, 2};

    rst_n = 1'b0; start = 1'b0; a_in = 8'd0; b_in = 8'd0;
    #12;
    check("reset_outputs", {busy, done, err, iter_cnt, gcd_out}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].g, vecs[i].n,
             vecs[i].e, vecs[i].edges);
    end

    // Result is held through idle cycles
    repeat (3) @(posedge clk);
    #1;
    check("hold_gcd", gcd_out, 1);
    check("hold_iter", iter_cnt, 1);

    // start held high continuously: the DONE-cycle start is ignored
    @(negedge clk);
    a_in = 8'd7; b_in = 8'd2; start = 1'b1;
    mask = 9'd0;
    for (int j = 0; j < 9; j++) begin
      if (j > 0) @(posedge clk);
      else @(posedge clk);
      #1;
      mask[j] = done;
    end
    start = 1'b0;
    check("b2b_done_mask", mask, 9'h108);
    @(posedge clk); #1;
    check("b2b_gcd", gcd_out, 1);

    // start pulsed while busy must not disturb the running computation
    @(negedge clk);
    a_in = 8'd233; b_in = 8'd144; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    a_in = 8'd9; b_in = 8'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(k);
    check("busy_ign_edges", k, 8);
    check("busy_ign_gcd", gcd_out, 1);
    check("busy_ign_iter", iter_cnt, 11);
    @(posedge clk); #1;

    // Reset mid-CALC: outputs clear immediately, no done afterwards
    @(negedge clk);
    a_in = 8'd5; b_in = 8'd13; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1.5;
    check("rst_mid_outputs", {busy, done, err, iter_cnt, gcd_out}, 0);
    #1.5;
    rst_n = 1'b1;
    bad = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done || busy) bad++;
    end
    check("rst_no_done", bad, 0);

    // Reset again mid-CALC; start is accepted on the first edge after release
    @(negedge clk);
    a_in = 8'd5; b_in = 8'd13; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    #1;
    a_in = 8'd9; b_in = 8'd6; start = 1'b1;
    go("rst_restart", 3, 2, 1'b0, 3);

    // Random operands against the reference model
    for (int r = 0; r < 40; r++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      if (r % 10 == 3) ra = 8'd0;
      if (r % 10 == 7) rb = 8'd0;
      ref_gcd(int'(ra), int'(rb), g, n, e, edges);
      run_op($sformatf("rnd%0d_%0d_%0d", r, ra, rb), ra, rb, g, n, e, edges);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
